// File: rtl/uart_tx_param.sv
// rtl/uart_tx_param.sv - FIFO-buffered UART transmitter with parameterised frame format
// Optional even/odd parity bit between data and stop bits when UART_PARITY_EN is defined.
module uart_tx_param #(
  parameter int CLK_RATE   = 10000000,
  parameter int BAUD_RATE  = 19200,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_en,
  input  logic [DATA_BITS-1:0]        wr_data,
  input  logic                        parity_odd,
  output logic                        RsTx,
  output logic                        tx_ready,
  output logic                        tx_busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overflow
);

  localparam int DIV = (CLK_RATE + BAUD_RATE / 2) / BAUD_RATE;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = $clog2(STOP_BITS * DIV + 1);
  localparam int BW  = $clog2(DATA_BITS);

  localparam logic [CW-1:0] BIT_LAST   = CW'(DIV - 1);
  localparam logic [CW-1:0] STOP_LAST  = CW'(STOP_BITS * DIV - 1);
  localparam logic [BW-1:0] DATA_LAST  = BW'(DATA_BITS - 1);
  localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t               state;
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [DATA_BITS-1:0] shift_reg;
  logic [CW-1:0]        baud_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] head;
  logic                 full;
  logic                 empty;
  logic                 pop;
  logic                 accept;

`ifdef UART_PARITY_EN
  logic par_bit;
`else
  logic unused_parity_odd;
  assign unused_parity_odd = parity_odd;
`endif

  assign head  = mem[rd_ptr];
  assign full  = (fifo_count == FULL_COUNT);
  assign empty = (fifo_count == '0);

  // A pop at the last stop cycle chains the next frame with no idle gap,
  // and it frees a slot so a write to a full FIFO in that cycle is kept.
  assign pop    = !empty && ((state == IDLE) || (state == STOP && baud_cnt == STOP_LAST));
  assign accept = wr_en && (!full || pop);

  assign tx_ready = !full;
  assign tx_busy  = (state != IDLE) || !empty;

  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      RsTx       <= 1'b1;
      fifo_count <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      overflow   <= 1'b0;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
`ifdef UART_PARITY_EN
      par_bit    <= 1'b0;
`endif
    end else begin
      if (accept) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      if (accept && !pop) fifo_count <= fifo_count + (AW + 1)'(1);
      else if (pop && !accept) fifo_count <= fifo_count - (AW + 1)'(1);
      if (wr_en && !accept) overflow <= 1'b1;

      if (pop) begin
        state     <= START;
        baud_cnt  <= '0;
        RsTx      <= 1'b0;
        shift_reg <= head;
`ifdef UART_PARITY_EN
        par_bit   <= (^head) ^ parity_odd;
`endif
      end else begin
        case (state)
          IDLE: begin
            RsTx     <= 1'b1;
            baud_cnt <= '0;
          end
          START: begin
            if (baud_cnt == BIT_LAST) begin
              state     <= DATA;
              baud_cnt  <= '0;
              bit_cnt   <= '0;
              RsTx      <= shift_reg[0];
              shift_reg <= shift_reg >> 1;
            end else begin
              baud_cnt <= baud_cnt + CW'(1);
            end
          end
          DATA: begin
            if (baud_cnt == BIT_LAST) begin
              baud_cnt <= '0;
              if (bit_cnt == DATA_LAST) begin
`ifdef UART_PARITY_EN
                state <= PARITY;
                RsTx  <= par_bit;
`else
                state <= STOP;
                RsTx  <= 1'b1;
`endif
              end else begin
                bit_cnt   <= bit_cnt + BW'(1);
                RsTx      <= shift_reg[0];
                shift_reg <= shift_reg >> 1;
              end
            end else begin
              baud_cnt <= baud_cnt + CW'(1);
            end
          end
`ifdef UART_PARITY_EN
          PARITY: begin
            if (baud_cnt == BIT_LAST) begin
              state    <= STOP;
              baud_cnt <= '0;
              RsTx     <= 1'b1;
            end else begin
              baud_cnt <= baud_cnt + CW'(1);
            end
          end
`endif
          // The stop phase spans all stop bits in one count.
          STOP: begin
            if (baud_cnt == STOP_LAST) begin
              state    <= IDLE;
              baud_cnt <= '0;
            end else begin
              baud_cnt <= baud_cnt + CW'(1);
            end
          end
          default: begin
            state    <= IDLE;
            RsTx     <= 1'b1;
            baud_cnt <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// tb/tb_uart_tx_param.sv - directed bench for uart_tx_param
// Three instances: defaults, fast divider (DIV 10), and 7 data bits with 2 stop bits.
module tb_uart_tx_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst0, rst_c, parity_odd;
  logic       wr_en0, wr_en1, wr_en2;
  logic [7:0] wr_data0, wr_data1;
  logic [6:0] wr_data2;
  logic       RsTx0, RsTx1, RsTx2;
  logic       tx_ready0, tx_ready1, tx_ready2;
  logic       tx_busy0, tx_busy1, tx_busy2;
  logic       overflow0, overflow1, overflow2;
  logic [4:0] fifo_count0, fifo_count1, fifo_count2;

  int checks = 0;
  int errors = 0;

  logic [15:0] pat1;
  int          n1;
  int          lows;

`ifdef UART_PARITY_EN
  localparam logic [15:0] PAT55 = 16'h04AA;
  localparam logic [15:0] PAT41 = 16'h0682;
  localparam logic [15:0] PAT2A = 16'h0754;
  localparam int          N8    = 11;
  localparam int          N7    = 11;
`else
  localparam logic [15:0] PAT55 = 16'h02AA;
  localparam logic [15:0] PAT41 = 16'h0382;
  localparam logic [15:0] PAT2A = 16'h0354;
  localparam int          N8    = 10;
  localparam int          N7    = 10;
`endif

  uart_tx_param u0 (
    .clk(clk), .rst(rst0), .wr_en(wr_en0), .wr_data(wr_data0), .parity_odd(parity_odd),
    .RsTx(RsTx0), .tx_ready(tx_ready0), .tx_busy(tx_busy0), .fifo_count(fifo_count0),
    .overflow(overflow0)
  );

  uart_tx_param #(.CLK_RATE(100), .BAUD_RATE(10)) u1 (
    .clk(clk), .rst(rst_c), .wr_en(wr_en1), .wr_data(wr_data1), .parity_odd(parity_odd),
    .RsTx(RsTx1), .tx_ready(tx_ready1), .tx_busy(tx_busy1), .fifo_count(fifo_count1),
    .overflow(overflow1)
  );

  uart_tx_param #(.DATA_BITS(7), .STOP_BITS(2)) u2 (
    .clk(clk), .rst(rst_c), .wr_en(wr_en2), .wr_data(wr_data2), .parity_odd(parity_odd),
    .RsTx(RsTx2), .tx_ready(tx_ready2), .tx_busy(tx_busy2), .fifo_count(fifo_count2),
    .overflow(overflow2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic line(input int k);
    case (k)
      0:       return RsTx0;
      1:       return RsTx1;
      default: return RsTx2;
    endcase
  endfunction

  function automatic logic busy(input int k);
    case (k)
      0:       return tx_busy0;
      1:       return tx_busy1;
      default: return tx_busy2;
    endcase
  endfunction

  function automatic logic [7:0] word(input int i);
    return 8'((i * 29 + 3) & 255);
  endfunction

  // Reference frame for an 8-bit, 1-stop, even-parity (when enabled) word.
  function automatic void mk_frame8(input logic [7:0] d, output logic [15:0] pat, output int n);
    pat = '0;
    n   = 1;
    for (int i = 0; i < 8; i++) begin
      pat[n] = d[i];
      n++;
    end
`ifdef UART_PARITY_EN
    pat[n] = ^d;
    n++;
`endif
    pat[n] = 1'b1;
    n++;
  endfunction

  // Every bit of the frame must hold its level for exactly div cycles.
  task automatic expect_frame(input int k, input int div, input logic [15:0] pat, input int n,
                              input bit wait_start, input string tag);
    int   good;
    int   t;
    logic busy_last;
    busy_last = 1'b0;
    if (wait_start) begin
      t = 0;
      while (line(k) !== 1'b0 && t < 20000) begin
        @(negedge clk);
        t++;
      end
      chk({tag, "_start"}, 32'(line(k)), 0);
    end
    for (int i = 0; i < n; i++) begin
      good = 0;
      for (int c = 0; c < div; c++) begin
        if (line(k) === pat[i]) good++;
        if (i == n - 1 && c == div - 1) busy_last = busy(k);
        @(negedge clk);
      end
      chk($sformatf("%s_bit%0d", tag, i), 32'(good), 32'(div));
    end
    chk({tag, "_busy_last"}, 32'(busy_last), 1);
  endtask

  initial begin
    rst0 = 1'b0; rst_c = 1'b0; parity_odd = 1'b0;
    wr_en0 = 1'b0; wr_en1 = 1'b0; wr_en2 = 1'b0;
    wr_data0 = '0; wr_data1 = '0; wr_data2 = '0;
    repeat (3) @(negedge clk);
    chk("rst_tx", 32'(RsTx0), 1);
    chk("rst_ready", 32'(tx_ready0), 1);
    chk("rst_busy", 32'(tx_busy0), 0);
    chk("rst_count", 32'(fifo_count0), 0);
    chk("rst_ovf", 32'(overflow0), 0);
    chk("rst_tx2", 32'(RsTx2), 1);
    rst0 = 1'b1; rst_c = 1'b1;
    @(negedge clk);

    // Single 0x55 frame from idle: pop one edge after the write.
    wr_en0 = 1'b1; wr_data0 = 8'h55;
    @(negedge clk);
    wr_en0 = 1'b0;
    chk("lat_tx_high", 32'(RsTx0), 1);
    chk("lat_count1", 32'(fifo_count0), 1);
    chk("lat_busy", 32'(tx_busy0), 1);
    @(negedge clk);
    chk("lat_tx_low", 32'(RsTx0), 0);
    chk("lat_count0", 32'(fifo_count0), 0);
    expect_frame(0, 521, PAT55, N8, 1'b0, "f55");
    chk("f55_idle_busy", 32'(tx_busy0), 0);
    chk("f55_idle_tx", 32'(RsTx0), 1);

    // Reset mid-DATA with a word still queued.
    wr_en0 = 1'b1; wr_data0 = 8'hA3;
    @(negedge clk);
    wr_data0 = 8'h11;
    @(negedge clk);
    wr_en0 = 1'b0;
    chk("mid_count", 32'(fifo_count0), 1);
    chk("mid_start", 32'(RsTx0), 0);
    repeat (3 * 521) @(negedge clk);
    rst0 = 1'b0;
    @(negedge clk);
    rst0 = 1'b1;
    chk("abort_tx", 32'(RsTx0), 1);
    chk("abort_count", 32'(fifo_count0), 0);
    chk("abort_busy", 32'(tx_busy0), 0);
    chk("abort_ready", 32'(tx_ready0), 1);
    lows = 0;
    for (int c = 0; c < 6000; c++) begin
      if (RsTx0 !== 1'b1 || tx_busy0 !== 1'b0) lows++;
      @(negedge clk);
    end
    chk("abort_quiet", 32'(lows), 0);

    // 7 data bits, 2 stop bits: 1042 high cycles then the next start bit.
    wr_en2 = 1'b1; wr_data2 = 7'h41;
    @(negedge clk);
    wr_data2 = 7'h2A;
    @(negedge clk);
    wr_en2 = 1'b0;
    expect_frame(2, 521, PAT41, N7, 1'b1, "f41");
    expect_frame(2, 521, PAT2A, N7, 1'b0, "f2a");
    chk("f2a_idle_busy", 32'(tx_busy2), 0);

    // Burst into depth-16 FIFO, then one write while full.
    fork
      begin
        for (int i = 0; i < 17; i++) begin
          wr_en1 = 1'b1; wr_data1 = word(i);
          @(negedge clk);
        end
        chk("full_count", 32'(fifo_count1), 16);
        chk("full_ready", 32'(tx_ready1), 0);
        chk("full_no_ovf", 32'(overflow1), 0);
        wr_data1 = 8'hEE;
        @(negedge clk);
        wr_en1 = 1'b0;
        chk("ovf_count", 32'(fifo_count1), 16);
        chk("ovf_flag", 32'(overflow1), 1);
      end
      begin
        for (int i = 0; i < 17; i++) begin
          mk_frame8(word(i), pat1, n1);
          expect_frame(1, 10, pat1, n1, i == 0, $sformatf("burst%0d", i));
        end
      end
    join
    chk("burst_idle_busy", 32'(tx_busy1), 0);
    chk("burst_idle_count", 32'(fifo_count1), 0);
    chk("burst_ovf_sticky", 32'(overflow1), 1);

`ifdef UART_PARITY_EN
    // parity_odd changes during the first frame; only the second pop sees it.
    fork
      begin
        wr_en1 = 1'b1; wr_data1 = 8'h07;
        @(negedge clk);
        wr_en1 = 1'b0;
        repeat (4) @(negedge clk);
        parity_odd = 1'b1;
        wr_en1 = 1'b1;
        @(negedge clk);
        wr_en1 = 1'b0;
      end
      begin
        expect_frame(1, 10, 16'h060E, 11, 1'b1, "par_even");
        expect_frame(1, 10, 16'h040E, 11, 1'b0, "par_odd");
      end
    join
    parity_odd = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
